// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
package hazard_ctrl_pkg;

  // Controller states; encodings are shared with the pipeline-register modules.
  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  // Architectural zero register; writes to it never create a dependency.
  localparam logic [2:0] REG_ZERO = 3'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Count up on inc, holding at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + WIDTH'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: boot priming, load-use stalls,
// taken-branch flushes, data-memory freezes and performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W       = 3,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned BOOT_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_br_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST  = BOOT_W'(BOOT_CYCLES - 1);
  localparam logic [WAIT_W:0]   TIMEOUT_V  = (WAIT_W + 1)'(MEM_TIMEOUT);
  localparam bit                TIMEOUT_EN = (MEM_TIMEOUT != 0);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [BOOT_W-1:0]   r_boot_cnt;
  logic [BOOT_W-1:0]   w_boot_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WAIT_W-1:0]   w_wait_nxt;
  logic [WAIT_W:0]     w_wait_inc;
  logic                r_mem_timeout;
  logic                w_timeout_set;
  logic                w_load_use;
  logic                w_active;
  logic                w_stall_inc;
  logic                w_flush_inc;

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  assign w_load_use = ex_mem_read && (ex_rt != REG_W'(REG_ZERO)) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  assign w_wait_inc = {1'b0, r_wait_cnt} + (WAIT_W + 1)'(1);

  // State, boot/wait counters and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BOOT;
      r_boot_cnt    <= '0;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_boot_cnt <= w_boot_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_timeout_set) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  // Next-state and same-cycle pipeline control decode.
  always_comb begin
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b0;
    halted        = 1'b0;
    w_state_nxt   = r_state;
    w_boot_nxt    = r_boot_cnt;
    w_wait_nxt    = r_wait_cnt;
    w_timeout_set = 1'b0;
    w_flush_inc   = 1'b0;
    w_active      = 1'b0;

    case (r_state)
      ST_BOOT: begin
        if_id_flush  = 1'b1;
        id_ex_write  = 1'b1;
        id_ex_bubble = 1'b1;
        ex_mem_write = 1'b1;
        if (r_boot_cnt == BOOT_LAST) begin
          w_state_nxt = ST_RUN;
          w_boot_nxt  = '0;
        end else begin
          w_boot_nxt = r_boot_cnt + BOOT_W'(1);
        end
      end

      ST_RUN, ST_MEM_WAIT: begin
        w_active = 1'b1;
        if (mem_busy) begin
          // Freeze every stage until the data memory is ready.
          if (r_state == ST_RUN) begin
            w_state_nxt = ST_MEM_WAIT;
            w_wait_nxt  = WAIT_W'(1);
          end else begin
            w_wait_nxt = w_wait_inc[WAIT_W] ? r_wait_cnt : w_wait_inc[WAIT_W-1:0];
            if (TIMEOUT_EN && (w_wait_inc >= TIMEOUT_V)) begin
              w_state_nxt   = ST_HALT;
              w_timeout_set = 1'b1;
            end
          end
        end else begin
          w_state_nxt  = ST_RUN;
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          id_ex_write  = 1'b1;
          ex_mem_write = 1'b1;
          if (ex_br_taken) begin
            // Branch squashes the wrong-path instructions in IF/ID and ID/EX.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            w_flush_inc  = 1'b1;
          end else if (w_load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  assign w_stall_inc = w_active & ~pc_write;
  assign mem_timeout = r_mem_timeout;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall_inc),
    .q     (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_flush_inc),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: default instance plus a small
// instance (CNT_W=4, MEM_TIMEOUT=4) for timeout and saturation.
module tb_hazard_ctrl;

  // Control vector: {pc_w, if_id_w, if_id_flush, id_ex_w, id_ex_bubble, ex_mem_w, halted, mem_timeout}
  localparam logic [7:0] V_BOOT    = 8'b0011_1100;
  localparam logic [7:0] V_RUN     = 8'b1101_0100;
  localparam logic [7:0] V_FRZ     = 8'b0000_0000;
  localparam logic [7:0] V_BR      = 8'b1111_1100;
  localparam logic [7:0] V_LU      = 8'b0001_1100;
  localparam logic [7:0] V_HALT_TO = 8'b0000_0011;

  typedef struct packed {
    logic       lr;
    logic [2:0] rt;
    logic [2:0] rs;
    logic [2:0] idrt;
    logic       urt;
    logic       br;
    logic       busy;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, ex_br_taken, mem_busy;

  logic        a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_write;
  logic        a_id_ex_bubble, a_ex_mem_write, a_halted, a_mem_timeout;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic        t_pc_write, t_if_id_write, t_if_id_flush, t_id_ex_write;
  logic        t_id_ex_bubble, t_ex_mem_write, t_halted, t_mem_timeout;
  logic [3:0]  t_stall_cnt, t_flush_cnt;
  logic [7:0]  a_ctrl, t_ctrl;

  logic [7:0] exp_q[$];
  logic [7:0] expt_q[$];
  int checks = 0;
  int failures = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  assign a_ctrl = {a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_write,
                   a_id_ex_bubble, a_ex_mem_write, a_halted, a_mem_timeout};
  assign t_ctrl = {t_pc_write, t_if_id_write, t_if_id_flush, t_id_ex_write,
                   t_id_ex_bubble, t_ex_mem_write, t_halted, t_mem_timeout};

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
    .pc_write(a_pc_write), .if_id_write(a_if_id_write), .if_id_flush(a_if_id_flush),
    .id_ex_write(a_id_ex_write), .id_ex_bubble(a_id_ex_bubble), .ex_mem_write(a_ex_mem_write),
    .halted(a_halted), .mem_timeout(a_mem_timeout), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
    .pc_write(t_pc_write), .if_id_write(t_if_id_write), .if_id_flush(t_if_id_flush),
    .id_ex_write(t_id_ex_write), .id_ex_bubble(t_id_ex_bubble), .ex_mem_write(t_ex_mem_write),
    .halted(t_halted), .mem_timeout(t_mem_timeout), .stall_cnt(t_stall_cnt), .flush_cnt(t_flush_cnt)
  );

  function automatic vec_t mk(input logic lr, input logic [2:0] rt, input logic [2:0] rs,
                              input logic [2:0] idrt, input logic urt, input logic br,
                              input logic busy, input logic [7:0] exp);
    vec_t v;
    v.lr = lr; v.rt = rt; v.rs = rs; v.idrt = idrt;
    v.urt = urt; v.br = br; v.busy = busy; v.exp = exp;
    return v;
  endfunction

  // Drive one cycle of inputs and record the expected control vector.
  task automatic apply(input vec_t v, input bit to_a, input bit to_t);
    ex_mem_read = v.lr; ex_rt = v.rt; id_rs = v.rs; id_rt = v.idrt;
    id_uses_rt = v.urt; ex_br_taken = v.br; mem_busy = v.busy;
    if (to_a) exp_q.push_back(v.exp);
    if (to_t) expt_q.push_back(v.exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst_n = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, V_BOOT), 1, 1);
    @(negedge clk);
    got = exp_q.pop_front();
    checks++;
    if (a_ctrl !== got) begin failures++; $display("FAIL reset_ctrl: got %b expected %b", a_ctrl, got); end
    got = expt_q.pop_front();
    checks++;
    if (t_ctrl !== got) begin failures++; $display("FAIL reset_ctrl_t: got %b expected %b", t_ctrl, got); end
    checks++;
    if (a_stall_cnt !== 16'd0 || a_flush_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_cnt: stall=%0d flush=%0d expected 0 0", a_stall_cnt, a_flush_cnt);
    end
    tick();
    rst_n = 1'b1;
    exp_stall = 0; exp_flush = 0;
    for (int c = 0; c < 5; c++) begin
      if (c < 4) apply(mk(1, 3'd3, 3'd3, 3'd3, 1, 1, 1, V_BOOT), 1, 1);
      else       apply(mk(0, 0, 0, 0, 0, 0, 0, V_RUN), 1, 1);
      @(negedge clk);
      got = exp_q.pop_front();
      checks++;
      if (a_ctrl !== got) begin failures++; $display("FAIL boot[%0d]: got %b expected %b", c, a_ctrl, got); end
      got = expt_q.pop_front();
      checks++;
      if (t_ctrl !== got) begin failures++; $display("FAIL boot_t[%0d]: got %b expected %b", c, t_ctrl, got); end
      tick();
    end
    checks++;
    if (a_stall_cnt !== 16'd0 || a_flush_cnt !== 16'd0) begin
      failures++; $display("FAIL boot_cnt: stall=%0d flush=%0d expected 0 0", a_stall_cnt, a_flush_cnt);
    end
  endtask

  task automatic test_load_use();
    vec_t tbl[4];
    logic [7:0] got;
    tbl[0] = mk(1, 3'd3, 3'd3, 3'd0, 0, 0, 0, V_LU);
    tbl[1] = mk(0, 3'd3, 3'd3, 3'd0, 0, 0, 0, V_RUN);
    tbl[2] = mk(1, 3'd5, 3'd2, 3'd5, 1, 0, 0, V_LU);
    tbl[3] = mk(0, 3'd0, 3'd0, 3'd0, 0, 0, 0, V_RUN);
    for (int i = 0; i < 4; i++) begin
      apply(tbl[i], 1, 0);
      if (tbl[i].exp == V_LU) exp_stall++;
      @(negedge clk);
      got = exp_q.pop_front();
      checks++;
      if (a_ctrl !== got) begin failures++; $display("FAIL load_use[%0d]: got %b expected %b", i, a_ctrl, got); end
      tick();
    end
    checks++;
    if (a_stall_cnt !== 16'(exp_stall)) begin
      failures++; $display("FAIL load_use_stall_cnt: got %0d expected %0d", a_stall_cnt, exp_stall);
    end
  endtask

  task automatic test_no_stall();
    vec_t tbl[5];
    logic [7:0] got;
    tbl[0] = mk(1, 3'd0, 3'd0, 3'd0, 1, 0, 0, V_RUN);
    tbl[1] = mk(1, 3'd4, 3'd1, 3'd4, 0, 0, 0, V_RUN);
    tbl[2] = mk(0, 3'd6, 3'd6, 3'd6, 1, 0, 0, V_RUN);
    tbl[3] = mk(1, 3'd5, 3'd2, 3'd3, 1, 0, 0, V_RUN);
    tbl[4] = mk(1, 3'd7, 3'd7, 3'd1, 0, 0, 0, V_LU);
    for (int i = 0; i < 5; i++) begin
      apply(tbl[i], 1, 0);
      if (tbl[i].exp == V_LU) exp_stall++;
      @(negedge clk);
      got = exp_q.pop_front();
      checks++;
      if (a_ctrl !== got) begin failures++; $display("FAIL no_stall[%0d]: got %b expected %b", i, a_ctrl, got); end
      tick();
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, V_RUN), 0, 0);
    checks++;
    if (a_stall_cnt !== 16'(exp_stall)) begin
      failures++; $display("FAIL no_stall_cnt: got %0d expected %0d", a_stall_cnt, exp_stall);
    end
  endtask

  task automatic test_branch();
    vec_t tbl[3];
    logic [7:0] got;
    tbl[0] = mk(1, 3'd3, 3'd3, 3'd3, 1, 1, 0, V_BR);
    tbl[1] = mk(0, 3'd0, 3'd0, 3'd0, 0, 1, 0, V_BR);
    tbl[2] = mk(0, 3'd0, 3'd0, 3'd0, 0, 0, 0, V_RUN);
    for (int i = 0; i < 3; i++) begin
      apply(tbl[i], 1, 0);
      if (tbl[i].exp == V_BR) exp_flush++;
      @(negedge clk);
      got = exp_q.pop_front();
      checks++;
      if (a_ctrl !== got) begin failures++; $display("FAIL branch[%0d]: got %b expected %b", i, a_ctrl, got); end
      tick();
    end
    checks++;
    if (a_flush_cnt !== 16'(exp_flush) || a_stall_cnt !== 16'(exp_stall)) begin
      failures++;
      $display("FAIL branch_cnt: flush=%0d stall=%0d expected %0d %0d", a_flush_cnt, a_stall_cnt, exp_flush, exp_stall);
    end
  endtask

  task automatic test_mem_freeze();
    logic [7:0] got;
    for (int i = 0; i < 7; i++) begin
      if (i < 5)       apply(mk(0, 0, 0, 0, 0, 1, 1, V_FRZ), 1, 0);
      else if (i == 5) apply(mk(0, 0, 0, 0, 0, 1, 0, V_BR), 1, 0);
      else             apply(mk(0, 0, 0, 0, 0, 0, 0, V_RUN), 1, 0);
      if (i < 5) exp_stall++;
      if (i == 5) exp_flush++;
      @(negedge clk);
      got = exp_q.pop_front();
      checks++;
      if (a_ctrl !== got) begin failures++; $display("FAIL mem_freeze[%0d]: got %b expected %b", i, a_ctrl, got); end
      tick();
    end
    checks++;
    if (a_stall_cnt !== 16'(exp_stall) || a_flush_cnt !== 16'(exp_flush)) begin
      failures++;
      $display("FAIL freeze_cnt: stall=%0d flush=%0d expected %0d %0d", a_stall_cnt, a_flush_cnt, exp_stall, exp_flush);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] got;
    rst_n = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, V_BOOT), 0, 0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 7; i++) begin
      if (i < 5)       apply(mk(0, 0, 0, 0, 0, 0, 1, (i < 4) ? V_FRZ : V_HALT_TO), 0, 1);
      else if (i == 5) apply(mk(0, 0, 0, 0, 0, 0, 0, V_HALT_TO), 0, 1);
      else             apply(mk(1, 3'd3, 3'd3, 3'd3, 1, 1, 0, V_HALT_TO), 0, 1);
      @(negedge clk);
      got = expt_q.pop_front();
      checks++;
      if (t_ctrl !== got) begin failures++; $display("FAIL timeout[%0d]: got %b expected %b", i, t_ctrl, got); end
      tick();
    end
    checks++;
    if (t_stall_cnt !== 4'd4) begin failures++; $display("FAIL timeout_stall_cnt: got %0d expected 4", t_stall_cnt); end
    rst_n = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, V_BOOT), 0, 1);
    @(negedge clk);
    got = expt_q.pop_front();
    checks++;
    if (t_ctrl !== got) begin failures++; $display("FAIL timeout_reset: got %b expected %b", t_ctrl, got); end
    checks++;
    if (t_stall_cnt !== 4'd0) begin failures++; $display("FAIL timeout_reset_cnt: got %0d expected 0", t_stall_cnt); end
    exp_stall = 0; exp_flush = 0;
  endtask

  task automatic test_saturate();
    logic [7:0] got;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 20; i++) begin
      apply(mk(1, 3'd3, 3'd3, 3'd0, 0, 0, 0, V_LU), 1, 1);
      exp_stall++;
      @(negedge clk);
      got = exp_q.pop_front();
      checks++;
      if (a_ctrl !== got) begin failures++; $display("FAIL sat[%0d]: got %b expected %b", i, a_ctrl, got); end
      got = expt_q.pop_front();
      checks++;
      if (t_ctrl !== got) begin failures++; $display("FAIL sat_t[%0d]: got %b expected %b", i, t_ctrl, got); end
      tick();
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, V_RUN), 0, 0);
    checks++;
    if (t_stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_hold: got %0d expected 15", t_stall_cnt); end
    checks++;
    if (a_stall_cnt !== 16'(exp_stall)) begin
      failures++; $display("FAIL sat_wide: got %0d expected %0d", a_stall_cnt, exp_stall);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    logic [7:0] got;
    apply(mk(1, 3'd2, 3'd2, 3'd0, 0, 0, 0, V_LU), 1, 0);
    #2;
    got = exp_q.pop_front();
    checks++;
    if (a_ctrl !== got) begin failures++; $display("FAIL mid_stall: got %b expected %b", a_ctrl, got); end
    rst_n = 1'b0;
    exp_q.push_back(V_BOOT);
    #1;
    got = exp_q.pop_front();
    checks++;
    if (a_ctrl !== got) begin failures++; $display("FAIL mid_reset: got %b expected %b", a_ctrl, got); end
    checks++;
    if (a_stall_cnt !== 16'd0) begin failures++; $display("FAIL mid_reset_cnt: got %0d expected 0", a_stall_cnt); end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      apply(mk(1, 3'd2, 3'd2, 3'd0, 0, 0, 0, (c < 4) ? V_BOOT : V_LU), 1, 0);
      @(negedge clk);
      got = exp_q.pop_front();
      checks++;
      if (a_ctrl !== got) begin failures++; $display("FAIL reprime[%0d]: got %b expected %b", c, a_ctrl, got); end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ex_mem_read = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0;
    id_uses_rt = 1'b0; ex_br_taken = 1'b0; mem_busy = 1'b0;
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_mem_freeze();
    test_timeout();
    test_saturate();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
